// File: rtl/bounce_sprite_engine.sv
// bounce_sprite_engine: N bouncing rectangles updated once per frame, rendered as a registered 3-bit RGB pixel
module bounce_sprite_engine #(
  parameter int N_SPRITES = 4,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int POS_W     = 10,
  parameter int SPEED_W   = 3
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic               display_on,
  input  logic               frame_tick,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               invert,
  output logic [2:0]         rgb,
  output logic               busy,
  output logic [15:0]        bounce_cnt
);
  localparam int IW = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;
  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - SPRITE_W);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - SPRITE_H);
  typedef enum logic {IDLE, UPDATE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [SPEED_W-1:0] spd;
  logic [POS_W-1:0] x [N_SPRITES];
  logic [POS_W-1:0] y [N_SPRITES];
  logic [N_SPRITES-1:0] dir_x, dir_y;
  logic [POS_W-1:0] sel_x, sel_y;
  logic sel_dx, sel_dy;
  logic [POS_W+1:0] nx, ny;
  logic [2:0] col;
  // Result packs {bounced, new_dir, new_pos}; math is one bit wider so p+s never wraps
  function automatic logic [POS_W+1:0] step(input logic [POS_W-1:0] p, input logic d,
                                            input logic [SPEED_W-1:0] s, input logic [POS_W-1:0] mx);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + (POS_W+1)'(s);
    if (d) return sum >= {1'b0, mx} ? {2'b10, mx} : {2'b01, sum[POS_W-1:0]};
    return {1'b0, p} <= (POS_W+1)'(s) ? {2'b11, {POS_W{1'b0}}} : {2'b00, p - POS_W'(s)};
  endfunction
  always_comb begin
    sel_x = x[0];
    sel_y = y[0];
    sel_dx = dir_x[0];
    sel_dy = dir_y[0];
    col = 3'd0;
    for (int i = 0; i < N_SPRITES; i++)
      if (IW'(i) == idx) begin
        sel_x = x[i];
        sel_y = y[i];
        sel_dx = dir_x[i];
        sel_dy = dir_y[i];
      end
    // Scan high to low so the lowest-index hit is written last and wins
    for (int i = N_SPRITES - 1; i >= 0; i--)
      if ({1'b0, hpos} >= {1'b0, x[i]} && {1'b0, hpos} < {1'b0, x[i]} + (POS_W+1)'(SPRITE_W) &&
          {1'b0, vpos} >= {1'b0, y[i]} && {1'b0, vpos} < {1'b0, y[i]} + (POS_W+1)'(SPRITE_H))
        col = 3'(i + 1);
  end
  assign nx = step(sel_x, sel_dx, spd, X_MAX);
  assign ny = step(sel_y, sel_dy, spd, Y_MAX);
  assign busy = state == UPDATE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      spd <= '0;
      rgb <= 3'd0;
      bounce_cnt <= 16'd0;
      for (int i = 0; i < N_SPRITES; i++) begin
        x[i] <= POS_W'(16 + 80 * i);
        y[i] <= POS_W'(16 + 48 * i);
        dir_x[i] <= 1'b1;
        dir_y[i] <= i % 2 == 0;
      end
    end else begin
      rgb <= display_on ? (invert ? ~col : col) : 3'd0;
      if (state == IDLE) begin
        if (frame_tick && !pause) begin
          state <= UPDATE;
          spd <= speed;
          idx <= '0;
        end
      end else begin
        for (int i = 0; i < N_SPRITES; i++)
          if (IW'(i) == idx) begin
            x[i] <= nx[POS_W-1:0];
            y[i] <= ny[POS_W-1:0];
            dir_x[i] <= nx[POS_W];
            dir_y[i] <= ny[POS_W];
          end
        bounce_cnt <= bounce_cnt + 16'(nx[POS_W+1]) + 16'(ny[POS_W+1]);
        idx <= idx + 1'b1;
        if (idx == IW'(N_SPRITES - 1)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bounce_sprite_engine.sv
// tb_bounce_sprite_engine: vector table plus scoreboarded pixel probes against a behavioural sprite model
`timescale 1ns/1ps
module tb_bounce_sprite_engine;
  logic clk = 0, rst = 1;
  logic [9:0] hpos = 0, vpos = 0;
  logic display_on = 0, frame_tick = 0, pause = 0, invert = 0;
  logic [2:0] speed = 0;
  logic [2:0] rgb;
  logic busy;
  logic [15:0] bounce_cnt;
  int errs = 0, chks = 0;
  int mx [4], my [4];
  bit mdx [4], mdy [4];
  int mbc;
  logic [2:0] sb [$];
  typedef struct { int h; int v; bit d; bit inv; logic [2:0] exp; } vec_t;
  vec_t tbl [12];
  bounce_sprite_engine dut (.clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_tick(frame_tick), .speed(speed), .pause(pause), .invert(invert), .rgb(rgb), .busy(busy),
    .bounce_cnt(bounce_cnt));
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string nm, input int got, input int exp);
    chks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 16 + 80 * i;
      my[i] = 16 + 48 * i;
      mdx[i] = 1;
      mdy[i] = i % 2 == 0;
    end
    mbc = 0;
  endtask
  task automatic axis(inout int p, inout bit d, input int s, input int lim);
    if (d && p + s >= lim) begin p = lim; d = 0; mbc++; end
    else if (!d && p <= s) begin p = 0; d = 1; mbc++; end
    else p = d ? p + s : p - s;
  endtask
  task automatic model_step(input int s);
    int p;
    bit d;
    for (int i = 0; i < 4; i++) begin
      p = mx[i]; d = mdx[i]; axis(p, d, s, 608); mx[i] = p; mdx[i] = d;
      p = my[i]; d = mdy[i]; axis(p, d, s, 448); my[i] = p; mdy[i] = d;
    end
  endtask
  function automatic logic [2:0] mcol(input int h, input int v);
    for (int i = 0; i < 4; i++)
      if (h >= mx[i] && h < mx[i] + 32 && v >= my[i] && v < my[i] + 32) return 3'(i + 1);
    return 3'd0;
  endfunction
  task automatic pix_exp(input int h, input int v, input bit d, input bit inv, input logic [2:0] e, input string nm);
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); display_on = d; invert = inv;
    sb.push_back(e);
    @(negedge clk);
    check(nm, rgb, sb.pop_front());
  endtask
  task automatic pix(input int h, input int v, input string nm);
    logic [2:0] c;
    c = mcol(h, v);
    pix_exp(h, v, 1, 0, c, nm);
  endtask
  task automatic do_tick(input int s, output int nb);
    @(negedge clk);
    speed = 3'(s); frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    nb = 0;
    while (busy && nb < 20) begin nb++; @(negedge clk); end
    if (!pause) model_step(s);
  endtask
  initial begin
    int nb, found, px, py, bc0;
    tbl[0]  = '{16, 16, 1, 0, 3'd1};
    tbl[1]  = '{16, 16, 1, 1, 3'd6};
    tbl[2]  = '{16, 16, 0, 1, 3'd0};
    tbl[3]  = '{16, 16, 0, 0, 3'd0};
    tbl[4]  = '{15, 16, 1, 0, 3'd0};
    tbl[5]  = '{47, 47, 1, 0, 3'd1};
    tbl[6]  = '{48, 16, 1, 0, 3'd0};
    tbl[7]  = '{96, 64, 1, 0, 3'd2};
    tbl[8]  = '{95, 64, 1, 0, 3'd0};
    tbl[9]  = '{176, 112, 1, 0, 3'd3};
    tbl[10] = '{256, 160, 1, 0, 3'd4};
    tbl[11] = '{0, 0, 1, 1, 3'd7};
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rgb", rgb, 0);
    check("reset_busy", busy, 0);
    check("reset_bounce", bounce_cnt, 0);
    rst = 0;
    foreach (tbl[k]) pix_exp(tbl[k].h, tbl[k].v, tbl[k].d, tbl[k].inv, tbl[k].exp, $sformatf("vec%0d", k));
    do_tick(1, nb);
    check("tick1_busy_len", nb, 4);
    pix_exp(17, 17, 1, 0, 3'd1, "s0_at_17_17");
    pix_exp(16, 17, 1, 0, 3'd0, "s0_left_clear");
    pix_exp(17, 16, 1, 0, 3'd0, "s0_top_clear");
    pix_exp(97, 63, 1, 0, 3'd2, "s1_at_97_63");
    pix_exp(96, 63, 1, 0, 3'd0, "s1_left_clear");
    pix_exp(97, 62, 1, 0, 3'd0, "s1_top_clear");
    while (mx[0] < 606) do_tick(606 - mx[0] > 7 ? 7 : 606 - mx[0], nb);
    check("approach_bounce", bounce_cnt, mbc & 16'hffff);
    bc0 = mbc;
    do_tick(3, nb);
    pix_exp(608, my[0], 1, 0, 3'd1, "edge_x608");
    pix(607, my[0], "edge_x607");
    check("edge_bounce", bounce_cnt, mbc & 16'hffff);
    check("edge_bounce_min", int'(mbc - bc0 >= 1), 1);
    do_tick(3, nb);
    pix_exp(605, my[0], 1, 0, 3'd1, "rebound_x605");
    pix_exp(636, my[0], 1, 0, 3'd1, "rebound_x636");
    pix(637, my[0], "rebound_x637");
    pix(604, my[0], "rebound_x604");
    @(negedge clk);
    speed = 2; frame_tick = 1;
    nb = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      frame_tick = k == 1;
      nb += int'(busy);
    end
    model_step(2);
    check("tick_in_busy_len", nb, 4);
    pix(mx[0], my[0], "after_ignored_s0");
    pix(mx[1], my[1], "after_ignored_s1");
    pause = 1;
    do_tick(5, nb);
    pause = 0;
    check("pause_busy_len", nb, 0);
    pix(mx[0], my[0], "pause_s0");
    pix(mx[2] - 1, my[2], "pause_s2_edge");
    do_tick(0, nb);
    check("speed0_busy_len", nb, 4);
    pix(mx[0], my[0], "speed0_s0");
    pix(mx[3], my[3], "speed0_s3");
    check("speed0_bounce", bounce_cnt, mbc & 16'hffff);
    found = 0;
    for (int t = 0; t < 800 && found < 3; t++) begin
      do_tick(1 + (t * 5) % 7, nb);
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (found < 3 && mx[i] - mx[j] < 32 && mx[j] - mx[i] < 32 && my[i] - my[j] < 32 && my[j] - my[i] < 32) begin
            px = mx[i] > mx[j] ? mx[i] : mx[j];
            py = my[i] > my[j] ? my[i] : my[j];
            pix(px, py, $sformatf("overlap_%0d_%0d", i, j));
            found++;
          end
    end
    check("overlap_found", int'(found > 0), 1);
    check("wander_bounce", bounce_cnt, mbc & 16'hffff);
    @(negedge clk);
    speed = 4; frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_bounce", bounce_cnt, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    pix_exp(16, 16, 1, 0, 3'd1, "midreset_s0");
    pix_exp(15, 16, 1, 0, 3'd0, "midreset_s0_left");
    pix_exp(96, 64, 1, 0, 3'd2, "midreset_s1");
    pix_exp(96, 63, 1, 0, 3'd0, "midreset_s1_top");
    pix_exp(256, 160, 1, 0, 3'd4, "midreset_s3");
    check("midreset_busy_after", busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule

// File: doc/bounce_sprite_engine.md
# bounce_sprite_engine

Parametrised multi-sprite bouncing-object renderer for the VGA tile. It holds N_SPRITES axis-aligned rectangles, advances each one once per frame with edge clamping and direction reversal, and produces a registered 3-bit RGB pixel from the live hpos/vpos beam position. It sits between hvsync_generator and the top-level uo_out mapping and generalises the single fixed-speed square to several sprites with selectable speed, pause, fixed priority and bounce counting.

## Interface

Parameters:

- N_SPRITES, 4: number of sprites, 1..7.
- SPRITE_W, 32: sprite width in pixels.
- SPRITE_H, 32: sprite height in pixels.
- H_ACTIVE, 640: visible width.
- V_ACTIVE, 480: visible height.
- POS_W, 10: position and beam coordinate width.
- SPEED_W, 3: speed input width.

Ports:

- clk  in  1: pixel clock.
- rst  in  1: asynchronous, active-high reset.
- hpos  in  POS_W: beam x from hvsync_generator.
- vpos  in  POS_W: beam y from hvsync_generator.
- display_on  in  1: beam is in the active area.
- frame_tick  in  1: one-cycle pulse per frame, asserted in vertical blank.
- speed  in  SPEED_W: pixels per frame per axis; sampled at frame_tick.
- pause  in  1: when 1, frame_tick is ignored.
- invert  in  1: invert the RGB output inside the active area.
- rgb  out  3: registered pixel colour {B,G,R}.
- busy  out  1: the update FSM is running.
- bounce_cnt  out  16: total edge reversals since reset, wrapping.

## Operation

- Per-sprite state: x and y (POS_W bits each) and dir_x and dir_y (1 = increasing).
- Reset values: x_i = 16 + 80·i, y_i = 16 + 48·i; dir_x = 1 for all sprites; dir_y = 1 for even i and 0 for odd i.
- Bounds are X_MAX = H_ACTIVE − SPRITE_W and Y_MAX = V_ACTIVE − SPRITE_H.
- Update FSM has two states, IDLE and UPDATE, and a sprite index idx.
  - IDLE → UPDATE when frame_tick=1 and pause=0. On this transition, latch speed into spd and clear idx to 0.
  - UPDATE: update sprite idx in one cycle, then increment idx. When idx = N_SPRITES−1, return to IDLE.
  - frame_tick while in UPDATE is ignored; it is not queued.
- Per-axis update, evaluated at POS_W+1 bits so nothing overflows; the x axis is shown and y uses the same rules with Y_MAX:
  - Increasing and x + spd ≥ X_MAX: set x ← X_MAX and dir ← 0. This counts as a bounce.
  - Decreasing and x ≤ spd: set x ← 0 and dir ← 1. This counts as a bounce.
  - Otherwise x ← x ± spd.
  - spd = 0 never moves a sprite. It still bounces a sprite already sitting on a bound in the direction of that bound.
- bounce_cnt increments by the number of axis bounces in that cycle (0, 1 or 2). It wraps modulo 2^16.
- Pixel hit for sprite i: x_i ≤ hpos < x_i + SPRITE_W and y_i ≤ vpos < y_i + SPRITE_H.
- Priority: the lowest index wins. The colour of sprite i is (i+1) as a 3-bit value. With no hit the colour is 0.
- Output colour:
  - display_on = 0: rgb ← 0, regardless of invert.
  - display_on = 1: rgb ← colour, or ~colour when invert = 1.
- Pixel hit testing uses current positions. The integrator pulses frame_tick in vblank, so updates never tear the visible image.

## Timing

- Reset values: rgb = 0, busy = 0, bounce_cnt = 0, FSM in IDLE, sprites at their reset values. Asserting rst mid-UPDATE aborts the update immediately and restores every sprite.
- rgb has 1-cycle latency: the rgb sampled at edge k+1 reflects the hpos, vpos, display_on and invert values present at edge k.
- busy is 1 for exactly N_SPRITES cycles, starting the cycle after the accepted frame_tick.
- Sprite i holds its new position from edge (tick + 2 + i) onward, counting the frame_tick edge as edge tick + 1.
- pause is sampled only in IDLE. Asserting pause during UPDATE does not stop the pass in progress.

## Test plan

- Reset: assert rst → rgb=0, busy=0, bounce_cnt=0, sprite0 at (16,16), sprite1 at (96,64).
- One tick with speed=1 and N=4 → busy high for 4 cycles; sprite0 at (17,17), sprite1 at (97,63).
- Right edge: set sprite0 so that x=606 and speed=3 with X_MAX=608 → x=608, dir_x=0, bounce_cnt+1. Next tick → x=605.
- Ignored and frozen inputs: frame_tick pulsed during busy → no second pass. pause=1 → tick ignored and positions unchanged. speed=0 → positions unchanged.
- Pixel path: beam at (16,16) with display_on=1 → rgb=3'b001 one cycle later. Same beam with invert=1 → 3'b110. display_on=0 → 3'b000. Where sprites 0 and 1 overlap → 3'b001.
- Reset mid-update: assert rst during cycle 2 of UPDATE → busy=0 and all sprites at their reset values.
